// File: rtl/ir_grid_pkg.sv
// Shared constants and index helpers for the 5x5 IR sensor grid.
// Cell index = row*GRID_DIM + col.
package ir_grid_pkg;

  localparam int GRID_DIM = 5;
  localparam int N_CELLS  = 25;
  localparam int IDX_W    = 5;

  function automatic logic [2:0] idx_row(input logic [IDX_W-1:0] idx);
    logic [2:0] row;
    case (idx) inside
      [5'd0 : 5'd4]:   row = 3'd0;
      [5'd5 : 5'd9]:   row = 3'd1;
      [5'd10 : 5'd14]: row = 3'd2;
      [5'd15 : 5'd19]: row = 3'd3;
      default:         row = 3'd4;
    endcase
    return row;
  endfunction

  function automatic logic [2:0] idx_col(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] row_base;
    row_base = IDX_W'(idx_row(idx)) * IDX_W'(GRID_DIM);
    return 3'(idx - row_base);
  endfunction

  // Bit i set when cell i is a 4-neighbour of idx.
  function automatic logic [N_CELLS-1:0] adj_mask(input logic [IDX_W-1:0] idx);
    logic [N_CELLS-1:0] mask;
    logic [2:0] row;
    logic [2:0] col;
    row  = idx_row(idx);
    col  = idx_col(idx);
    mask = '0;
    if (col != 3'd0) mask[idx - 5'd1] = 1'b1;
    if (col != 3'(GRID_DIM - 1)) mask[idx + 5'd1] = 1'b1;
    if (row != 3'd0) mask[idx - 5'(GRID_DIM)] = 1'b1;
    if (row != 3'(GRID_DIM - 1)) mask[idx + 5'(GRID_DIM)] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// Per-cell IR conditioning: two-flop synchroniser into a saturating
// low-time counter; stable is high once the line has been low long enough.
module ir_debounce
  import ir_grid_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  input  logic clr,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      // The synchroniser keeps running through a round clear, so a held
      // cell restarts debounce immediately from zero.
      if (s || clr)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/ir_trace_latch.sv
// Latches debounced IR touches as traced cells and reports each new one.
// Optional build macro TRACE_ADJ_EN restricts grants to 4-neighbours of the last cell.
module ir_trace_latch
  import ir_grid_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_CELLS-1:0] ir_raw,
  input  logic               clear_trace,
  output logic [N_CELLS-1:0] ir_out,
  output logic               new_cell_valid,
  output logic [IDX_W-1:0]   new_cell_idx,
  output logic [IDX_W-1:0]   traced_count,
  output logic               all_traced
);

  logic [N_CELLS-1:0] stable;
  logic [N_CELLS-1:0] pending;
  logic [N_CELLS-1:0] traced;
  logic [N_CELLS-1:0] qualified;
  logic [N_CELLS-1:0] grant_vec;
  logic               has_grant;
  logic [IDX_W-1:0]   grant_idx;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    ir_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .resetn(resetn),
      .raw   (ir_raw[i]),
      .clr   (clear_trace),
      .stable(stable[i])
    );
  end

`ifdef TRACE_ADJ_EN
  logic first_done;

  always_comb begin
    qualified = pending;
    if (first_done)
      qualified = pending & adj_mask(new_cell_idx);
  end
`else
  assign qualified = pending;
`endif

  always_comb begin
    has_grant = 1'b0;
    grant_idx = '0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (qualified[i]) begin
        has_grant = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    grant_vec = has_grant ? (N_CELLS'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending        <= '0;
      traced         <= '0;
      new_cell_valid <= 1'b0;
      new_cell_idx   <= '0;
      traced_count   <= '0;
    end else if (clear_trace) begin
      pending        <= '0;
      traced         <= '0;
      new_cell_valid <= 1'b0;
      traced_count   <= '0;
    end else begin
      // Granted bit is masked last: its stable input is still high this cycle.
      pending        <= (qualified | (stable & ~traced)) & ~grant_vec;
      traced         <= traced | grant_vec;
      new_cell_valid <= has_grant;
      if (has_grant) begin
        new_cell_idx <= grant_idx;
        traced_count <= traced_count + IDX_W'(1);
      end
    end
  end

`ifdef TRACE_ADJ_EN
  always_ff @(posedge clk) begin
    if (!resetn || clear_trace)
      first_done <= 1'b0;
    else if (has_grant)
      first_done <= 1'b1;
  end
`endif

  assign ir_out     = ~traced;
  assign all_traced = (traced_count == IDX_W'(N_CELLS));

endmodule

// File: tb/tb_ir_trace_latch.sv
// Randomised and directed bench for ir_trace_latch against a cycle-level
// reference model of the touch/accept/grant rules.
module tb_ir_trace_latch;

  localparam int N  = 25;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  ir_raw = '1;
  logic          clear_trace = 1'b0;
  logic [N-1:0]  ir_out;
  logic          new_cell_valid;
  logic [4:0]    new_cell_idx;
  logic [4:0]    traced_count;
  logic          all_traced;

  int n_chk  = 0;
  int n_fail = 0;

  ir_trace_latch #(.DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ir_raw        (ir_raw),
    .clear_trace   (clear_trace),
    .ir_out        (ir_out),
    .new_cell_valid(new_cell_valid),
    .new_cell_idx  (new_cell_idx),
    .traced_count  (traced_count),
    .all_traced    (all_traced)
  );

  always #5 clk = ~clk;

  // Reference model: a cell is accepted once its delayed line has been low
  // for DB consecutive cycles since the last reset/clear.
  bit [N-1:0] m_traced, m_pend, m_d1, m_d2;
  int         m_run [N];
  bit         m_valid, m_first;
  int         m_idx, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit adjacent(input int a, input int b);
    int dr, dc;
    dr = a / 5 - b / 5;
    dc = a % 5 - b % 5;
    if (dr < 0) dr = -dr;
    if (dc < 0) dc = -dc;
    return (dr + dc) == 1;
  endfunction

  task automatic model_edge(input bit rst_n, input bit [N-1:0] raw, input bit clr);
    bit [N-1:0] stab, cand;
    int g;
    if (!rst_n) begin
      m_traced = '0; m_pend = '0; m_valid = 0; m_idx = 0; m_count = 0; m_first = 0;
      foreach (m_run[i]) m_run[i] = 0;
      m_d1 = '1; m_d2 = '1;
      return;
    end
    for (int i = 0; i < N; i++) stab[i] = (m_run[i] >= DB);
    if (clr) begin
      m_traced = '0; m_pend = '0; m_count = 0; m_valid = 0; m_first = 0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      cand = m_pend;
`ifdef TRACE_ADJ_EN
      if (m_first)
        for (int i = 0; i < N; i++) if (!adjacent(i, m_idx)) cand[i] = 0;
`endif
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (cand[i]) g = i;
      m_pend = cand | (stab & ~m_traced);
      if (g >= 0) begin
        m_pend[g] = 0; m_traced[g] = 1; m_valid = 1; m_idx = g; m_count++; m_first = 1;
      end else begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++)
        m_run[i] = m_d2[i] ? 0 : ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]);
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  task automatic step(input logic [N-1:0] raw, input logic clr, input logic rst_n);
    @(negedge clk);
    ir_raw = raw; clear_trace = clr; resetn = rst_n;
    @(posedge clk);
    model_edge(rst_n, raw, clr);
    #1;
    chk("ir_out", ir_out, m_traced ^ {N{1'b1}});
    chk("valid", new_cell_valid, m_valid);
    chk("idx", new_cell_idx, m_idx);
    chk("count", traced_count, m_count);
    chk("all_traced", all_traced, m_count == N);
  endtask

  logic [N-1:0] raw_v;
  int ev_idx[$];
  int ev_step[$];
  int any_v;

  initial begin
    for (int k = 0; k < 3; k++) step('1, 1'b0, 1'b0);
    chk("rst_ir_out", ir_out, 25'h1FFFFFF);
    chk("rst_valid", new_cell_valid, 0);
    chk("rst_idx", new_cell_idx, 0);

    any_v = 0;
    for (int k = 0; k < 20; k++) begin
      step('1, 1'b0, 1'b1);
      any_v |= new_cell_valid;
    end
    chk("idle_ir_out", ir_out, 25'h1FFFFFF);
    chk("idle_count", traced_count, 0);
    chk("idle_valid", any_v, 0);

    // Single touch: event on edge DB+3 counting the first low sample as edge 0.
    raw_v = '1; raw_v[7] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(raw_v, 1'b0, 1'b1);
      chk("t7_valid", new_cell_valid, k == DB + 3);
      if (k == DB + 3) chk("t7_idx", new_cell_idx, 7);
    end
    chk("t7_ir_out", ir_out[7], 0);
    chk("t7_count", traced_count, 1);

    any_v = 0;
    for (int k = 0; k < 10; k++) begin step('1, 1'b0, 1'b1); any_v |= new_cell_valid; end
    for (int k = 0; k < 12; k++) begin step(raw_v, 1'b0, 1'b1); any_v |= new_cell_valid; end
    chk("retouch_valid", any_v, 0);
    chk("retouch_count", traced_count, 1);

    // Glitches shorter than the debounce window on an untraced and a traced cell.
    any_v = 0;
    for (int c = 0; c < 2; c++) begin
      raw_v = '1; raw_v[c == 0 ? 9 : 7] = 1'b0;
      for (int k = 0; k < DB - 1; k++) begin step(raw_v, 1'b0, 1'b1); any_v |= new_cell_valid; end
      for (int k = 0; k < 10; k++) begin step('1, 1'b0, 1'b1); any_v |= new_cell_valid; end
    end
    chk("glitch_valid", any_v, 0);
    chk("glitch_ir_out", ir_out, 25'h1FFFFFF & ~(25'd1 << 7));

    step('1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step('1, 1'b0, 1'b1);

    raw_v = '1; raw_v[3] = 0; raw_v[12] = 0; raw_v[20] = 0;
    ev_idx.delete(); ev_step.delete();
    for (int k = 0; k < 14; k++) begin
      step(raw_v, 1'b0, 1'b1);
      if (new_cell_valid) begin ev_idx.push_back(new_cell_idx); ev_step.push_back(k); end
    end
`ifndef TRACE_ADJ_EN
    chk("multi_nev", ev_idx.size(), 3);
    if (ev_idx.size() == 3) begin
      chk("multi_i0", ev_idx[0], 3);
      chk("multi_i1", ev_idx[1], 12);
      chk("multi_i2", ev_idx[2], 20);
      chk("multi_consec", ev_step[2] - ev_step[0], 2);
    end
    chk("multi_count", traced_count, 3);
`endif

    step('1, 1'b1, 1'b1);
    ev_idx.delete();
    for (int k = 0; k < 45; k++) begin
      step('0, 1'b0, 1'b1);
      if (new_cell_valid) ev_idx.push_back(new_cell_idx);
    end
`ifndef TRACE_ADJ_EN
    chk("all_nev", ev_idx.size(), 25);
    for (int i = 0; i < ev_idx.size(); i++) chk("all_order", ev_idx[i], i);
    chk("all_traced", all_traced, 1);
    chk("all_ir_out", ir_out, 0);
`endif

    step('0, 1'b1, 1'b1);
    chk("clr_ir_out", ir_out, 25'h1FFFFFF);
    chk("clr_count", traced_count, 0);
    chk("clr_valid", new_cell_valid, 0);
    any_v = -1;
    // Clear edge is the first of the 7 edges; the re-trace lands on the last.
    for (int k = 1; k < 12; k++) begin
      step('0, 1'b0, 1'b1);
      if (new_cell_valid && any_v < 0) any_v = k;
    end
    chk("retrace_edge", any_v, 6);

`ifdef TRACE_ADJ_EN
    step('1, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) step('1, 1'b0, 1'b1);
    raw_v = '1; raw_v[12] = 0;
    for (int k = 0; k < 10; k++) step(raw_v, 1'b0, 1'b1);
    chk("adj_first", new_cell_idx, 12);
    raw_v = '1; raw_v[0] = 0;
    any_v = 0;
    for (int k = 0; k < 14; k++) begin step(raw_v, 1'b0, 1'b1); any_v |= new_cell_valid; end
    chk("adj_nonadj", any_v, 0);
    raw_v[13] = 0;
    ev_idx.delete();
    for (int k = 0; k < 12; k++) begin
      step(raw_v, 1'b0, 1'b1);
      if (new_cell_valid) ev_idx.push_back(new_cell_idx);
    end
    chk("adj_nev", ev_idx.size(), 1);
    if (ev_idx.size() > 0) chk("adj_idx", ev_idx[0], 13);
`endif

    // Random phase: held patterns of sparse touches, occasional clears/resets.
    for (int blk = 0; blk < 200; blk++) begin
      int len;
      len = $urandom_range(1, 14);
      raw_v = '1;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) raw_v[i] = 1'b0;
      for (int k = 0; k < len; k++)
        step(raw_v, ($urandom_range(0, 79) == 0), ($urandom_range(0, 299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
